avalon_pio_ext: RTL

//  Parametrised Avalon-MM slave PIO; next generation of the single-bit I2C SCL/SDA output port.

---
 rtl/avalon_pio_pkg.sv | 21 ++
 rtl/avalon_pio_ext_if.sv | 21 ++
 rtl/avalon_pio_ext_sync_edge.sv | 69 ++++++
 rtl/avalon_pio_ext.sv | 113 +++++++++++
 4 files changed

// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM PIO: register word addresses and edge-capture modes.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_NONE = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_FALL = 2;
    localparam int EDGE_ANY  = 3;

    // Arm counter must hold SYNC_STAGES+1.
    function automatic int arm_width(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/avalon_pio_ext_if.sv
// Avalon-MM slave bus bundle for the PIO: address/strobe/data plus read data and interrupt.
interface avalon_pio_ext_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/avalon_pio_ext_sync_edge.sv
// Pin synchroniser with one-cycle history and edge detection, gated off until the
// chain has flushed after reset so idle-high pins are not captured as edges.
module pio_sync_edge
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_o
);

    localparam int              ARM_W   = arm_width(SYNC_STAGES);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
    logic [WIDTH-1:0]                  prev_q;
    logic [ARM_W-1:0]                  arm_q, arm_d;
    logic                              armed_s;
    logic [WIDTH-1:0]                  rise_s, fall_s, det_s;

    assign sync_o  = chain_q[SYNC_STAGES-1];
    assign armed_s = (arm_q == ARM_MAX);

    // Next state of the shift chain and the saturating arm counter.
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], pin_i};
        if (armed_s) begin
            arm_d = arm_q;
        end else begin
            arm_d = arm_q + ARM_W'(1);
        end
    end

    // Synchroniser, history and arm counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
            prev_q  <= '0;
            arm_q   <= '0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= chain_q[SYNC_STAGES-1];
            arm_q   <= arm_d;
        end
    end

    // Edge selection by mode, suppressed until armed.
    always_comb begin
        rise_s = chain_q[SYNC_STAGES-1] & ~prev_q;
        fall_s = ~chain_q[SYNC_STAGES-1] & prev_q;
        case (EDGE_TYPE)
            EDGE_RISE: det_s = rise_s;
            EDGE_FALL: det_s = fall_s;
            EDGE_ANY:  det_s = rise_s | fall_s;
            default:   det_s = '0;
        endcase
        if (armed_s) begin
            edge_o = det_s;
        end else begin
            edge_o = '0;
        end
    end

endmodule

// File: rtl/avalon_pio_ext.sv
// Avalon-MM PIO slave: per-bit direction, push-pull or open-drain drive, atomic set/clear,
// synchronised input read-back, edge capture with write-1-to-clear and a maskable level irq.
module avalon_pio_ext
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int               OPEN_DRAIN  = 0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
)(
    input  logic                clk,
    input  logic                reset,
    avalon_pio_ext_if.slave     bus,
    input  logic [WIDTH-1:0]    pio_in,
    output logic [WIDTH-1:0]    pio_out,
    output logic [WIDTH-1:0]    pio_oe
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [WIDTH-1:0] ecap_clr_s, wdata_s, sync_s, edge_s;
    logic             irq_q, irq_d;
    logic             wr_s;
    logic [31:0]      rdata_s;
    logic             unused_wdata_s;

    assign wr_s           = bus.chipselect & ~bus.write_n;
    assign wdata_s        = bus.writedata[WIDTH-1:0];
    assign unused_wdata_s = ^bus.writedata;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (reset),
        .pin_i  (pio_in),
        .sync_o (sync_s),
        .edge_o (edge_s)
    );

    // Register writes; a new edge takes priority over a simultaneous clear.
    always_comb begin
        dout_d     = dout_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        ecap_clr_s = '0;
        if (wr_s) begin
            case (bus.address)
                ADDR_DATA:    dout_d     = wdata_s;
                ADDR_DIR:     dir_d      = wdata_s;
                ADDR_IRQMASK: mask_d     = wdata_s;
                ADDR_EDGECAP: ecap_clr_s = wdata_s;
                ADDR_OUTSET:  dout_d     = dout_q | wdata_s;
                ADDR_OUTCLR:  dout_d     = dout_q & ~wdata_s;
                default:      dout_d     = dout_q;
            endcase
        end else begin
            dout_d = dout_q;
        end
        ecap_d = (ecap_q & ~ecap_clr_s) | edge_s;
        irq_d  = |(ecap_q & mask_q);
    end

    // Register file and interrupt flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= RESET_OUT;
            dir_q  <= RESET_DIR;
            mask_q <= '0;
            ecap_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            ecap_q <= ecap_d;
            irq_q  <= irq_d;
        end
    end

    // Zero-wait read mux; set/clear ports and unused addresses read as zero.
    always_comb begin
        rdata_s = 32'd0;
        case (bus.address)
            ADDR_DATA:    rdata_s[WIDTH-1:0] = sync_s;
            ADDR_DIR:     rdata_s[WIDTH-1:0] = dir_q;
            ADDR_IRQMASK: rdata_s[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: rdata_s[WIDTH-1:0] = ecap_q;
            default:      rdata_s            = 32'd0;
        endcase
    end

    // Open-drain releases the line for '1' and only ever pulls low.
    always_comb begin
        if (OPEN_DRAIN != 0) begin
            pio_out = '0;
            pio_oe  = dir_q & ~dout_q;
        end else begin
            pio_out = dout_q;
            pio_oe  = dir_q;
        end
    end

    assign bus.readdata = rdata_s;
    assign bus.irq      = irq_q;

endmodule
